// File: rtl/pll_phase_ctrl.sv
// Run-time phase stepping for PLLA outputs via PSSEL/PSDIR/PSPULSE.
// Tracks per-channel phase, filters lock and aborts on lock loss.
module pll_phase_ctrl #(
  parameter int CHANNELS  = 7,
  parameter int STEP_W    = 6,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 8,
  parameter int LOCK_FILT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_chan,
  input  logic [STEP_W-1:0] req_phase,
  input  logic [2:0]        rd_chan,
  output logic [STEP_W-1:0] rd_phase,
  output logic [2:0]        pll_pssel,
  output logic              pll_psdir,
  output logic              pll_pspulse,
  output logic              locked,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int LW   = $clog2(LOCK_FILT + 1);

  localparam logic [LW-1:0] LF    = LW'(LOCK_FILT);
  localparam logic [LW-1:0] LF_M1 = LW'(LOCK_FILT - 1);
  localparam logic [TW-1:0] P_LD  = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] G_LD  = TW'(GAP_LEN - 1);
  localparam logic [STEP_W-1:0] HALF =
    {1'b1, {(STEP_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t            state;
  logic [LW-1:0]     lock_cnt;
  logic [2:0]        chan_q;
  logic [STEP_W-1:0] tgt_q;
  logic [STEP_W-1:0] steps_q;
  logic [TW-1:0]     tmr;
  logic              pspulse_q;
  logic [STEP_W-1:0] phase_q [8];
  logic [STEP_W-1:0] diff;
  logic              bad_chan;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
    end else if (!pll_lock) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LF) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Current cycle counts toward the filter so loss drops locked at once
  assign locked = pll_lock && (lock_cnt >= LF_M1);

  assign req_ready   = (state == S_IDLE) && locked;
  assign busy        = (state != S_IDLE);
  assign pll_pspulse = pspulse_q && locked;

  assign diff     = tgt_q - phase_q[chan_q];
  assign bad_chan = (int'(chan_q) >= CHANNELS);

  assign rd_phase = (int'(rd_chan) < CHANNELS) ?
                    phase_q[rd_chan] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      chan_q    <= '0;
      tgt_q     <= '0;
      steps_q   <= '0;
      tmr       <= '0;
      pspulse_q <= 1'b0;
      pll_pssel <= '0;
      pll_psdir <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 8; i++) phase_q[i] <= '0;
    end else begin
      done <= 1'b0;
      // PLL reloads its static phases on relock
      if (!locked) begin
        for (int i = 0; i < 8; i++) phase_q[i] <= '0;
      end
      if (state != S_IDLE && !locked) begin
        state     <= S_IDLE;
        pspulse_q <= 1'b0;
        pll_pssel <= '0;
        pll_psdir <= 1'b0;
        err       <= 1'b1;
        done      <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (req_valid && req_ready) begin
              chan_q <= req_chan;
              tgt_q  <= req_phase;
              err    <= 1'b0;
              state  <= S_CALC;
            end
          end
          S_CALC: begin
            if (bad_chan) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (diff == '0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              pll_pssel <= chan_q;
              pll_psdir <= (diff > HALF);
              steps_q   <= (diff > HALF) ? -diff : diff;
              state     <= S_SETUP;
            end
          end
          S_SETUP: begin
            pspulse_q <= 1'b1;
            tmr       <= P_LD;
            state     <= S_PULSE;
          end
          S_PULSE: begin
            if (tmr == '0) begin
              pspulse_q <= 1'b0;
              tmr       <= G_LD;
              steps_q   <= steps_q - 1'b1;
              phase_q[chan_q] <= pll_psdir ?
                phase_q[chan_q] - 1'b1 :
                phase_q[chan_q] + 1'b1;
              state     <= S_GAP;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_GAP: begin
            if (tmr != '0) begin
              tmr <= tmr - 1'b1;
            end else if (steps_q != '0) begin
              pspulse_q <= 1'b1;
              tmr       <= P_LD;
              state     <= S_PULSE;
            end else begin
              done  <= 1'b1;
              state <= S_FINISH;
            end
          end
          S_FINISH: begin
            pll_pssel <= '0;
            pll_psdir <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
